// File: rtl/clk_reset_seq_pkg.sv
// rtl/clk_reset_seq_pkg.sv - shared state type and default constants for the clock/reset sequencer
package clk_reset_seq_pkg;

   typedef enum logic [1:0] {
      WAIT_LOCK = 2'd0,
      FILTER    = 2'd1,
      HOLD      = 2'd2,
      RUN       = 2'd3
   } seq_state_t;

   localparam int LOCK_FILTER_DEF = 16;
   localparam int RST_HOLD_DEF    = 1024;
   localparam int CE_NUM_DEF      = 15;
   localparam int CE_DEN_DEF      = 168;
   localparam int LOST_CNT_W      = 8;

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchroniser for a single asynchronous level, cleared to 0
module sync_2ff (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_d,
   output logic o_q
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_d;
         r_sync <= r_meta;
      end
   end

   assign o_q = r_sync;

endmodule

// File: rtl/clk_reset_sequencer.sv
// rtl/clk_reset_sequencer.sv - PLL lock qualification, core reset sequencing and fractional CPU clock-enable
module clk_reset_sequencer
   import clk_reset_seq_pkg::*;
#(
   parameter int LOCK_FILTER = LOCK_FILTER_DEF,
   parameter int RST_HOLD    = RST_HOLD_DEF,
   parameter int CE_NUM      = CE_NUM_DEF,
   parameter int CE_DEN      = CE_DEN_DEF
) (
   input  logic                  clk_sys,
   input  logic                  reset_n,
   input  logic                  pll_locked,
   input  logic                  rst_req,
   output logic                  sys_reset,
   output logic                  ce_cpu,
   output logic                  ready,
   output logic [LOST_CNT_W-1:0] lock_lost_cnt
);

   localparam int FLT_W  = $clog2(LOCK_FILTER + 1);
   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam int ACC_W  = $clog2(CE_DEN + CE_NUM);

   localparam logic [FLT_W-1:0]  FLT_LAST  = FLT_W'(LOCK_FILTER - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RST_HOLD - 1);
   localparam logic [ACC_W-1:0]  ACC_NUM   = ACC_W'(CE_NUM);
   localparam logic [ACC_W-1:0]  ACC_DEN   = ACC_W'(CE_DEN);

   seq_state_t        r_state;
   seq_state_t        w_next;
   logic [FLT_W-1:0]  r_flt_cnt;
   logic [FLT_W-1:0]  w_flt_nxt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [HOLD_W-1:0] w_hold_nxt;
   logic [ACC_W-1:0]  r_acc;
   logic [ACC_W-1:0]  w_sum;
   logic              w_lk_s;
   logic              w_lost_evt;
   logic              w_ce_run;

   sync_2ff u_lock_sync (
      .i_clk   (clk_sys),
      .i_rst_n (reset_n),
      .i_d     (pll_locked),
      .o_q     (w_lk_s)
   );

   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= WAIT_LOCK;
         r_flt_cnt  <= '0;
         r_hold_cnt <= '0;
      end else begin
         r_state    <= w_next;
         r_flt_cnt  <= w_flt_nxt;
         r_hold_cnt <= w_hold_nxt;
      end
   end

   // The locked cycle seen in WAIT_LOCK is the first of the LOCK_FILTER qualifying cycles.
   always_comb begin
      w_next     = r_state;
      w_flt_nxt  = r_flt_cnt;
      w_hold_nxt = r_hold_cnt;
      w_lost_evt = 1'b0;
      if (!w_lk_s) begin
         w_next     = WAIT_LOCK;
         w_flt_nxt  = '0;
         w_lost_evt = (r_state == HOLD) || (r_state == RUN);
      end else begin
         case (r_state)
            WAIT_LOCK: begin
               w_next    = FILTER;
               w_flt_nxt = FLT_W'(1);
            end
            FILTER: begin
               if (r_flt_cnt >= FLT_LAST) begin
                  w_next     = HOLD;
                  w_hold_nxt = '0;
               end else begin
                  w_flt_nxt = r_flt_cnt + 1'b1;
               end
            end
            HOLD: begin
               if (rst_req) begin
                  w_hold_nxt = '0;
               end else if (r_hold_cnt == HOLD_LAST) begin
                  w_next = RUN;
               end else begin
                  w_hold_nxt = r_hold_cnt + 1'b1;
               end
            end
            RUN: begin
               if (rst_req) begin
                  w_next     = HOLD;
                  w_hold_nxt = '0;
               end
            end
            default: w_next = WAIT_LOCK;
         endcase
      end
   end

   assign w_sum    = r_acc + ACC_NUM;
   assign w_ce_run = ((r_state == HOLD) || (r_state == RUN)) && (w_next != WAIT_LOCK);

   // Outputs decode the next state so they move on the same edge as the state register.
   always_ff @(posedge clk_sys or negedge reset_n) begin
      if (!reset_n) begin
         sys_reset     <= 1'b1;
         ready         <= 1'b0;
         ce_cpu        <= 1'b0;
         r_acc         <= '0;
         lock_lost_cnt <= '0;
      end else begin
         sys_reset <= (w_next != RUN);
         ready     <= (w_next == RUN);
         if (w_lost_evt && (lock_lost_cnt != '1)) begin
            lock_lost_cnt <= lock_lost_cnt + 1'b1;
         end
         if (!w_ce_run) begin
            r_acc  <= '0;
            ce_cpu <= 1'b0;
         end else if (w_sum >= ACC_DEN) begin
            r_acc  <= w_sum - ACC_DEN;
            ce_cpu <= 1'b1;
         end else begin
            r_acc  <= w_sum;
            ce_cpu <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_clk_reset_sequencer.sv
// tb/tb_clk_reset_sequencer.sv - scoreboard bench for the clock/reset sequencer
module tb_clk_reset_sequencer;

   logic       clk_sys;
   logic       reset_n;
   logic       pll_locked;
   logic       rst_req;
   logic       sys_reset;
   logic       ce_cpu;
   logic       ready;
   logic [7:0] lock_lost_cnt;

   typedef struct {
      int         cyc;
      logic       rst;
      logic       rdy;
      logic [7:0] lost;
   } ev_t;

   ev_t  q_rst[$];
   int   checks   = 0;
   int   failures = 0;
   int   cyc      = 0;
   int   ce_count = 0;
   int   first_ce = -1;
   int   last_ce  = -1;
   bit   gap_en   = 0;
   logic r_prev_rst = 1'b1;

   clk_reset_sequencer dut (
      .clk_sys       (clk_sys),
      .reset_n       (reset_n),
      .pll_locked    (pll_locked),
      .rst_req       (rst_req),
      .sys_reset     (sys_reset),
      .ce_cpu        (ce_cpu),
      .ready         (ready),
      .lock_lost_cnt (lock_lost_cnt)
   );

   initial clk_sys = 1'b0;
   always #6 clk_sys = ~clk_sys;

   always @(posedge clk_sys) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0d exp=%0d", name, got, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk_sys);
      #1;
   endtask

   task automatic push_ev(input int c, input logic r, input logic y, input logic [7:0] l);
      ev_t e;
      e.cyc  = c;
      e.rst  = r;
      e.rdy  = y;
      e.lost = l;
      q_rst.push_back(e);
   endtask

   // Monitor: every sys_reset transition must match the next expected event exactly.
   always @(negedge clk_sys) begin
      if (reset_n) begin
         if (sys_reset !== r_prev_rst) begin
            checks++;
            if (q_rst.size() == 0) begin
               failures++;
               $display("FAIL rst_unexpected cyc=%0d got sys_reset=%0b exp no change", cyc, sys_reset);
            end else begin
               ev_t e;
               e = q_rst.pop_front();
               if (cyc != e.cyc || sys_reset !== e.rst || ready !== e.rdy || lock_lost_cnt !== e.lost) begin
                  failures++;
                  $display("FAIL rst_event got cyc=%0d rst=%0b rdy=%0b lost=%0d exp cyc=%0d rst=%0b rdy=%0b lost=%0d",
                           cyc, sys_reset, ready, lock_lost_cnt, e.cyc, e.rst, e.rdy, e.lost);
               end
            end
         end
         if (ce_cpu === 1'b1) begin
            ce_count++;
            if (first_ce < 0) first_ce = cyc;
            if (gap_en && last_ce >= 0) begin
               checks++;
               if ((cyc - last_ce) != 11 && (cyc - last_ce) != 12) begin
                  failures++;
                  $display("FAIL ce_gap got=%0d exp=11or12 at cyc=%0d", cyc - last_ce, cyc);
               end
            end
            last_ce = cyc;
         end
      end
      r_prev_rst = sys_reset;
   end

   initial begin
      int c0;
      reset_n    = 1'b0;
      pll_locked = 1'b0;
      rst_req    = 1'b0;
      step(3);
      chk("reset_sys_reset", sys_reset, 1);
      chk("reset_ce_cpu", ce_cpu, 0);
      chk("reset_ready", ready, 0);
      chk("reset_lost", lock_lost_cnt, 0);
      reset_n = 1'b1;
      step(2);

      // Lock chatter with 5-cycle high phases never qualifies.
      ce_count = 0;
      for (int i = 0; i < 20; i++) begin
         pll_locked = 1'b1;
         step(5);
         pll_locked = 1'b0;
         step(5);
      end
      step(10);
      chk("chatter_sys_reset", sys_reset, 1);
      chk("chatter_lost", lock_lost_cnt, 0);
      chk("chatter_ce_count", ce_count, 0);

      // Clean lock: release after 2+16+1024 cycles, first strobe 12 cycles after HOLD entry.
      c0 = cyc;
      pll_locked = 1'b1;
      push_ev(c0 + 1042, 1'b0, 1'b1, 8'd0);
      first_ce = -1;
      last_ce  = -1;
      gap_en   = 1;
      step(40);
      chk("first_ce_cycle", first_ce - c0, 30);
      step(1010);
      chk("run_ready", ready, 1);

      ce_count = 0;
      step(1680);
      chk("ce_count_1680", ce_count, 150);

      // One-cycle rst_req in RUN: reset for RST_HOLD cycles, CE cadence continues.
      c0 = cyc;
      rst_req = 1'b1;
      push_ev(c0 + 1, 1'b1, 1'b0, 8'd0);
      push_ev(c0 + 1025, 1'b0, 1'b1, 8'd0);
      step(1);
      rst_req = 1'b0;
      step(1030);
      chk("rst_req_lost", lock_lost_cnt, 0);

      // One-cycle lock drop in RUN.
      gap_en = 0;
      c0 = cyc;
      pll_locked = 1'b0;
      push_ev(c0 + 3, 1'b1, 1'b0, 8'd1);
      push_ev(c0 + 1043, 1'b0, 1'b1, 8'd1);
      step(1);
      pll_locked = 1'b1;
      step(2);
      first_ce = -1;
      step(37);
      chk("relock_first_ce", first_ce - c0, 31);
      chk("drop_lost", lock_lost_cnt, 1);
      gap_en = 1;
      step(1010);
      gap_en = 0;

      // Remaining 299 losses, the first from RUN, the rest shortly after HOLD entry.
      for (int i = 0; i < 299; i++) begin
         c0 = cyc;
         pll_locked = 1'b0;
         if (i == 0) push_ev(c0 + 3, 1'b1, 1'b0, 8'd2);
         step(3);
         pll_locked = 1'b1;
         step(22);
         if (i == 100) chk("lost_mid", lock_lost_cnt, 102);
      end
      chk("lost_saturated", lock_lost_cnt, 255);

      // Asynchronous reset in the middle of HOLD.
      #2;
      reset_n = 1'b0;
      #1;
      chk("async_sys_reset", sys_reset, 1);
      chk("async_ce_cpu", ce_cpu, 0);
      chk("async_ready", ready, 0);
      chk("async_lost", lock_lost_cnt, 0);
      step(3);
      chk("scoreboard_drained", q_rst.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
